// File: rtl/async_fifo_core_if.sv
// rtl/async_fifo_core_if.sv - FIFO handshake bundle; overflow/underflow present with ASYNC_FIFO_ERR_FLAGS_EN
interface async_fifo_core_if #(
  parameter int Width = 8
);
  logic             w_en;
  logic             r_en;
  logic [Width-1:0] data_in;
  logic [Width-1:0] data_out;
  logic             full;
  logic             empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  modport master (
    output w_en, r_en, data_in,
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  data_out, full, empty
  );

  modport slave (
    input  w_en, r_en, data_in,
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output data_out, full, empty
  );
endinterface

// File: rtl/async_fifo_core.sv
// rtl/async_fifo_core.sv - single-clock FIFO with registered read data; ASYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
module async_fifo_core #(
  parameter int Width = 8,
  parameter int Depth = 8
) (
  input  logic              clk,
  input  logic              rst,
  async_fifo_core_if.slave  bus
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [Width-1:0] dout_q;
  logic             full_w;
  logic             empty_w;
  logic             wr_acc;
  logic             rd_acc;

  // Extra pointer MSB separates the full case from the empty case when addresses match.
  assign empty_w = (wptr == rptr);
  assign full_w  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign wr_acc  = bus.w_en && !full_w;
  assign rd_acc  = bus.r_en && !empty_w;

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.data_out = dout_q;

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[wptr[AW-1:0]] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      dout_q <= '0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + PTR_INC;
      end
      if (rd_acc) begin
        dout_q <= mem[rptr[AW-1:0]];
        rptr   <= rptr + PTR_INC;
      end
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.w_en && full_w) begin
        overflow_q <= 1'b1;
      end
      if (bus.r_en && empty_w) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_async_fifo_core.sv
// tb/tb_async_fifo_core.sv - scoreboard bench for async_fifo_core against a queue-based reference model
module tb_async_fifo_core;
  localparam int W = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  async_fifo_core_if #(.Width(W)) bus();

  async_fifo_core #(.Width(W), .Depth(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] dout;
    bit           full;
    bit           empty;
    bit           ovf;
    bit           udf;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [W-1:0] model_q[$];
  logic [W-1:0] m_dout;
  bit           m_ovf;
  bit           m_udf;
  int           n_cmp  = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, advance the model, queue the post-edge expectation.
  task automatic cycle(input bit w, input bit r, input logic [W-1:0] d, input bit do_rst);
    exp_t e;
    bit   was_full;
    bit   was_empty;
    @(negedge clk);
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    rst         = do_rst;
    if (do_rst) begin
      model_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      was_full  = (model_q.size() == D);
      was_empty = (model_q.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_dout = model_q.pop_front();
      if (w && !was_full)  model_q.push_back(d);
    end
    e.dout  = m_dout;
    e.full  = (model_q.size() == D);
    e.empty = (model_q.size() == 0);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    exp_q.push_back(e);
    if (do_rst) begin
      #1;
      check("rst_now_empty", 32'(bus.empty), 32'd1);
      check("rst_now_full", 32'(bus.full), 32'd0);
      check("rst_now_dout", 32'(bus.data_out), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("data_out", 32'(bus.data_out), 32'(mon_e.dout));
        check("full", 32'(bus.full), 32'(mon_e.full));
        check("empty", 32'(bus.empty), 32'(mon_e.empty));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check("overflow", 32'(bus.overflow), 32'(mon_e.ovf));
        check("underflow", 32'(bus.underflow), 32'(mon_e.udf));
`endif
      end
    end
  end

  initial begin
    rst         = 1'b1;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    bus.data_in = '0;
    m_dout      = '0;
    m_ovf       = 1'b0;
    m_udf       = 1'b0;

    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'hEE, 1'b1);

    // Fill to full, reject a ninth write, drain in order, then read while empty.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(8'hA1 + i), 1'b0);
    cycle(1'b1, 1'b0, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    // Simultaneous read/write while full: read wins, write dropped.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, W'(8'hB1 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

    // Simultaneous read/write while empty: write only, no bypass.
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, W'(i), 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
    end

    // Reset with five words stored, then a write released on the same edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(8'hC0 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'h99, 1'b1);
    cycle(1'b1, 1'b0, 8'h3C, 1'b0);
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 7 : 3;
      cycle($urandom_range(0, 9) < wp, $urandom_range(0, 9) >= wp,
            W'($urandom_range(0, 255)), $urandom_range(0, 79) == 0);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/async_fifo_core.md
ASYNC_FIFO_CORE -- requirements
Module: async_fifo_core

Interface
REQ-001 Parameter Width, default 8, data word width in bits.
REQ-002 Parameter Depth, default 8, number of storage entries; SHALL be a power of two, >= 2.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 w_en  input  1  write request.
REQ-007 r_en  input  1  read request.
REQ-008 data_in  input  Width  write data, sampled at the rising clk edge when a write is accepted.
REQ-009 data_out  output  Width  registered read data.
REQ-010 full  output  1  high when Depth words are stored.
REQ-011 empty  output  1  high when 0 words are stored.

Function
REQ-012 Storage SHALL be a Depth x Width array addressed by write and read pointers of log2(Depth)+1 bits; the extra MSB SHALL distinguish full from empty.
REQ-013 A write SHALL be accepted at a rising edge when w_en=1 and full=0: mem[wptr] <= data_in, wptr increments.
REQ-014 A read SHALL be accepted at a rising edge when r_en=1 and empty=0: data_out <= mem[rptr], rptr increments; read latency is one clock.
REQ-015 data_out SHALL hold its last value when no read is accepted.
REQ-016 empty SHALL equal (wptr == rptr); full SHALL equal (address bits equal and MSBs differ); both are decoded combinationally from registered pointers, so they reflect an accepted operation in the cycle after its edge.
REQ-017 Write while full SHALL be ignored: no pointer or memory change, no overwrite.
REQ-018 Read while empty SHALL be ignored: rptr and data_out unchanged.
REQ-019 Simultaneous w_en and r_en while neither full nor empty: both SHALL be accepted; occupancy unchanged.
REQ-020 Simultaneous w_en and r_en while full: the read SHALL be accepted and the write rejected (full is evaluated before the edge).
REQ-021 Simultaneous w_en and r_en while empty: the write SHALL be accepted, the read ignored; no write-to-read bypass.
REQ-022 Pointers SHALL wrap modulo 2*Depth; data order SHALL be strict first-in first-out across wrap-around.

Reset
REQ-023 While rst=1, asynchronously: wptr=0, rptr=0, data_out=0, empty=1, full=0; memory contents need not be cleared.
REQ-024 Reset asserted mid-operation SHALL discard all stored words; w_en and r_en SHALL be ignored while rst=1.
REQ-025 After rst deasserts, the first accepted write SHALL occur on the next rising clk edge.

Configuration
REQ-026 Macro ASYNC_FIFO_ERR_FLAGS_EN: when defined, outputs overflow (1 bit) and underflow (1 bit) SHALL exist; overflow sets on a rejected write (w_en=1, full=1), underflow on a rejected read (r_en=1, empty=1); both are sticky, cleared only by rst.
REQ-027 Without ASYNC_FIFO_ERR_FLAGS_EN the overflow and underflow ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 Reset held 50 time units then released -> empty=1, full=0, data_out=8'h00 throughout reset.
REQ-029 Write 8'hA1..8'hA8 (8 writes, no reads) -> full=1 after 8th edge, empty=0; 9th write 8'hFF ignored; reads return A1..A8 in order, then empty=1.
REQ-030 Read while empty with data_out=8'hA8 -> data_out stays 8'hA8, pointers unchanged; with macro defined, underflow=1 until rst.
REQ-031 Full FIFO, w_en=r_en=1 with data_in=8'h55 -> read returns oldest word, full falls to 0, 8'h55 not stored.
REQ-032 20 interleaved write/read pairs of values 0..19 (pointer wrap) -> outputs 0..19 in order, never full, empty after last read.
REQ-033 Assert rst with 5 words stored -> empty=1, full=0, data_out=0 immediately; subsequent write 8'h3C then read returns 8'h3C.
